wb_stage: RTL and testbench

// Writeback stage of the 8-bit pipeline; the write side of the ID-stage register file.

---
 rtl/wb_stage.sv | 130 +++++++++++++
 tb/tb_wb_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 8-bit pipeline.
// Accepts completed results from EX via valid/ready and holds them in an
// in-order circular queue. It issues one entry per cycle to the register-file
// write port. An entry arriving while the queue is empty goes straight to the
// port. ID read data is bypassed from pending results so ID never sees a
// stale register.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ex_valid/ex_ready                EX handshake; ex_ready depends only on count
//   ex_rd/ex_result/ex_regwrite      accepted entry fields
//   wb_hold                          blocks issue this cycle
//   flush                            drops every queued entry
//   Write_Reg_Num/Write_Data/RegWrite  registered register-file write port
//   id_rd_num/id_rd_data/id_rd_fwd   ID read address, raw data, bypassed data
//   retire_count                     issued-entry counter, wraps modulo 256
module wb_stage #(
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  output logic       ex_ready,
  input  logic [2:0] ex_rd,
  input  logic [7:0] ex_result,
  input  logic       ex_regwrite,
  input  logic       wb_hold,
  input  logic       flush,
  output logic [2:0] Write_Reg_Num,
  output logic [7:0] Write_Data,
  output logic       RegWrite,
  input  logic [2:0] id_rd_num,
  input  logic [7:0] id_rd_data,
  output logic [7:0] id_rd_fwd,
  output logic [7:0] retire_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]    q_rd   [DEPTH];
  logic [7:0]    q_data [DEPTH];
  logic          q_rw   [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_nxt;

  logic       accept, issue, push, pop, empty;
  logic [2:0] iss_rd;
  logic [7:0] iss_data;
  logic       iss_rw;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic r0_masked(input logic [2:0] rd);
    return (ZERO_REG != 0) && (rd == 3'd0);
  endfunction

  assign empty    = (count == '0);
  assign ex_ready = (count < CW'(DEPTH));

  // Flush blocks both sides of the queue for the edge it is sampled on.
  assign accept = ex_valid & ex_ready & ~flush;
  assign issue  = ~flush & ~wb_hold & (~empty | accept);
  // An accept into an empty queue that issues the same edge bypasses storage.
  assign pop    = issue & ~empty;
  assign push   = accept & ~(empty & issue);

  assign iss_rd   = empty ? ex_rd       : q_rd[head];
  assign iss_data = empty ? ex_result   : q_data[head];
  assign iss_rw   = empty ? ex_regwrite : q_rw[head];

  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      head          <= '0;
      tail          <= '0;
      Write_Reg_Num <= '0;
      Write_Data    <= '0;
      RegWrite      <= 1'b0;
      retire_count  <= '0;
    end else begin
      RegWrite <= 1'b0;
      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        count <= count_nxt;
        if (push) tail <= nxt(tail);
        if (pop)  head <= nxt(head);
        if (issue) begin
          Write_Reg_Num <= iss_rd;
          Write_Data    <= iss_data;
          RegWrite      <= iss_rw & ~r0_masked(iss_rd);
          retire_count  <= retire_count + 8'd1;
        end
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_rd[tail]   <= ex_rd;
      q_data[tail] <= ex_result;
      q_rw[tail]   <= ex_regwrite;
    end
  end

  // Bypass: start from the raw read, let the port write override it, then walk
  // the queue oldest to youngest so the youngest match wins.
  logic [PW-1:0] walk;
  always_comb begin
    id_rd_fwd = id_rd_data;
    walk      = head;
    if (RegWrite && Write_Reg_Num == id_rd_num)
      id_rd_fwd = Write_Data;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && q_rw[walk] && (q_rd[walk] == id_rd_num) &&
          !r0_masked(id_rd_num))
        id_rd_fwd = q_data[walk];
      walk = nxt(walk);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  logic       clk = 1'b0;
  logic       reset, ex_valid, ex_regwrite, wb_hold, flush;
  logic [2:0] ex_rd, id_rd_num;
  logic [7:0] ex_result, id_rd_data;

  logic       rdy0, rw0, rdy1, rw1;
  logic [2:0] wrn0, wrn1;
  logic [7:0] wd0, wd1, fwd0, fwd1, rc0, rc1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_stage #(.DEPTH(2), .ZERO_REG(0)) u0 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(rdy0),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_regwrite(ex_regwrite),
    .wb_hold(wb_hold), .flush(flush), .Write_Reg_Num(wrn0), .Write_Data(wd0),
    .RegWrite(rw0), .id_rd_num(id_rd_num), .id_rd_data(id_rd_data),
    .id_rd_fwd(fwd0), .retire_count(rc0));

  wb_stage #(.DEPTH(2), .ZERO_REG(1)) u1 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(rdy1),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_regwrite(ex_regwrite),
    .wb_hold(wb_hold), .flush(flush), .Write_Reg_Num(wrn1), .Write_Data(wd1),
    .RegWrite(rw1), .id_rd_num(id_rd_num), .id_rd_data(id_rd_data),
    .id_rd_fwd(fwd1), .retire_count(rc1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] rd, input logic [7:0] d, input logic w);
    ex_valid = 1'b1; ex_rd = rd; ex_result = d; ex_regwrite = w;
  endtask

  task automatic port(input string tag, input logic w, input logic [2:0] rn,
                      input logic [7:0] d, input logic [7:0] rc);
    chk({tag, ".RegWrite"}, 32'(rw0), 32'(w));
    chk({tag, ".Write_Reg_Num"}, 32'(wrn0), 32'(rn));
    chk({tag, ".Write_Data"}, 32'(wd0), 32'(d));
    chk({tag, ".retire_count"}, 32'(rc0), 32'(rc));
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_regwrite = 1'b0;
    wb_hold = 1'b0; flush = 1'b0; id_rd_num = '0; id_rd_data = '0;
    step(); step();
    reset = 1'b0;
    chk("rst.ex_ready", 32'(rdy0), 32'd1);
    port("rst", 1'b0, 3'd0, 8'h00, 8'd0);

    // Single write, latency 1 through the bypass.
    push(3'd3, 8'h5A, 1'b1);
    step();
    ex_valid = 1'b0;
    port("lat1", 1'b1, 3'd3, 8'h5A, 8'd1);
    step();
    port("lat1.after", 1'b0, 3'd3, 8'h5A, 8'd1);

    // Hold fills the queue, release drains it in order.
    wb_hold = 1'b1;
    push(3'd1, 8'h11, 1'b1);
    step();
    chk("hold1.ex_ready", 32'(rdy0), 32'd1);
    chk("hold1.RegWrite", 32'(rw0), 32'd0);
    push(3'd2, 8'h22, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("hold2.ex_ready", 32'(rdy0), 32'd0);
    id_rd_num = 3'd2; id_rd_data = 8'h77;
    #1 chk("fwd.q_r2", 32'(fwd0), 32'h22);
    id_rd_num = 3'd3;
    #1 chk("fwd.raw_r3", 32'(fwd0), 32'h77);
    wb_hold = 1'b0;
    step();
    port("drain1", 1'b1, 3'd1, 8'h11, 8'd2);
    chk("drain1.ex_ready", 32'(rdy0), 32'd1);
    id_rd_num = 3'd1;
    #1 chk("fwd.port_r1", 32'(fwd0), 32'h11);
    step();
    port("drain2", 1'b1, 3'd2, 8'h22, 8'd3);
    step();
    port("drain.idle", 1'b0, 3'd2, 8'h22, 8'd3);

    // Youngest queued entry wins the bypass.
    wb_hold = 1'b1;
    id_rd_num = 3'd4; id_rd_data = 8'h04;
    push(3'd4, 8'hAA, 1'b1);
    step();
    chk("fwd.AA", 32'(fwd0), 32'hAA);
    push(3'd4, 8'hBB, 1'b1);
    step();
    chk("fwd.BB", 32'(fwd0), 32'hBB);

    // Flush beats hold and refuses the entry offered on the same edge.
    push(3'd5, 8'h55, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; ex_valid = 1'b0;
    chk("flush.ex_ready", 32'(rdy0), 32'd1);
    chk("flush.fwd", 32'(fwd0), 32'h04);
    port("flush", 1'b0, 3'd2, 8'h22, 8'd3);
    wb_hold = 1'b0;
    step();
    port("flush.empty", 1'b0, 3'd2, 8'h22, 8'd3);

    // R0 suppression and regwrite=0 entries both retire.
    push(3'd0, 8'hFF, 1'b1);
    step();
    port("r0.u0", 1'b1, 3'd0, 8'hFF, 8'd4);
    chk("r0.u1.RegWrite", 32'(rw1), 32'd0);
    chk("r0.u1.retire", 32'(rc1), 32'd4);
    push(3'd6, 8'h66, 1'b0);
    step();
    ex_valid = 1'b0;
    port("nowrite", 1'b0, 3'd6, 8'h66, 8'd5);
    chk("nowrite.u1.retire", 32'(rc1), 32'd5);

    // Simultaneous accept+issue keeps FIFO order across pointer wrap.
    wb_hold = 1'b1;
    push(3'd1, 8'hA1, 1'b1);
    step();
    wb_hold = 1'b0;
    push(3'd2, 8'hB2, 1'b1);
    step();
    port("fifo1", 1'b1, 3'd1, 8'hA1, 8'd6);
    push(3'd3, 8'hC3, 1'b1);
    step();
    ex_valid = 1'b0;
    port("fifo2", 1'b1, 3'd2, 8'hB2, 8'd7);
    step();
    port("fifo3", 1'b1, 3'd3, 8'hC3, 8'd8);
    step();
    chk("fifo.idle", 32'(rw0), 32'd0);

    // R0 masking on the bypass path, then reset with a full queue.
    wb_hold = 1'b1;
    id_rd_num = 3'd0; id_rd_data = 8'h12;
    push(3'd0, 8'hFF, 1'b1);
    step();
    chk("fwd.r0.u0", 32'(fwd0), 32'hFF);
    chk("fwd.r0.u1", 32'(fwd1), 32'h12);
    push(3'd7, 8'h99, 1'b0);
    id_rd_num = 3'd7;
    step();
    ex_valid = 1'b0;
    chk("fwd.rw0", 32'(fwd0), 32'h12);
    chk("full.ex_ready", 32'(rdy0), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2.ex_ready", 32'(rdy0), 32'd1);
    port("rst2", 1'b0, 3'd0, 8'h00, 8'd0);
    chk("rst2.fwd", 32'(fwd0), 32'h12);

    // 256 back-to-back retires wrap the counter.
    wb_hold = 1'b0;
    for (int i = 0; i < 256; i++) begin
      push(3'(i), 8'(i), 1'b1);
      step();
      if (i == 254) chk("wrap.255", 32'(rc0), 32'd255);
    end
    ex_valid = 1'b0;
    port("wrap", 1'b1, 3'd7, 8'hFF, 8'd0);
    step();
    chk("wrap.idle", 32'(rw0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
